// File: rtl/fp_align_ctrl.sv
// Operand-alignment sequencer for the FP add/sub front end: orders two single-precision
// operands, drives the external right shifter and returns the aligned mantissa pair.
module fp_align_ctrl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic [SEL_W-1:0] sh_sel,
    output logic [MAN_W-1:0] sh_f,
    input  logic [MAN_W-1:0] sh_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] big_man,
    output logic [MAN_W-1:0] sml_man,
    output logic [EXP_W-1:0] exp_out,
    output logic             sign_big,
    output logic             sign_sml,
    output logic             swapped,
    output logic             sticky
);
    localparam int FRAC_W = MAN_W - 1;
    localparam int SGN_B  = FRAC_W + EXP_W;
    localparam logic [EXP_W-1:0] SAT_E  = EXP_W'((1 << SEL_W) - 1);
    localparam logic [EXP_W-1:0] MAN_WE = EXP_W'(MAN_W);

    typedef enum logic [1:0] {IDLE, ALIGN, HOLD} state_t;
    state_t r_state, w_next;

    logic [EXP_W-1:0] w_exp_a, w_exp_b, w_eexp_a, w_eexp_b;
    logic [EXP_W-1:0] w_eexp_big, w_eexp_sml, w_diff;
    logic [MAN_W-1:0] w_man_a, w_man_b, w_man_big, w_man_sml, w_mask;
    logic [SEL_W-1:0] w_sel;
    logic             w_a_big, w_sticky, w_accept, w_capture;

    // Denormals decode with effective exponent 1 and no hidden bit.
    assign w_exp_a  = op_a[FRAC_W +: EXP_W];
    assign w_exp_b  = op_b[FRAC_W +: EXP_W];
    assign w_eexp_a = (w_exp_a == '0) ? EXP_W'(1) : w_exp_a;
    assign w_eexp_b = (w_exp_b == '0) ? EXP_W'(1) : w_exp_b;
    assign w_man_a  = {(w_exp_a != '0), op_a[FRAC_W-1:0]};
    assign w_man_b  = {(w_exp_b != '0), op_b[FRAC_W-1:0]};

    assign w_a_big    = {w_eexp_a, w_man_a} >= {w_eexp_b, w_man_b};
    assign w_man_big  = w_a_big ? w_man_a  : w_man_b;
    assign w_man_sml  = w_a_big ? w_man_b  : w_man_a;
    assign w_eexp_big = w_a_big ? w_eexp_a : w_eexp_b;
    assign w_eexp_sml = w_a_big ? w_eexp_b : w_eexp_a;
    assign w_diff     = w_eexp_big - w_eexp_sml;
    assign w_sel      = (w_diff > SAT_E) ? SEL_W'(SAT_E) : w_diff[SEL_W-1:0];

    // Sticky is taken from the bits below the shift point, independent of the shifter.
    assign w_mask   = (w_diff >= MAN_WE) ? '1 : ~({MAN_W{1'b1}} << w_diff);
    assign w_sticky = |(w_man_sml & w_mask);

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_capture = (r_state == ALIGN);

    logic [MAN_W-1:0] r_big_q;
    logic [EXP_W-1:0] r_exp_q;
    logic             r_sgn_big_q, r_sgn_sml_q, r_swp_q, r_stk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_sel      <= '0;
            sh_f        <= '0;
            r_big_q     <= '0;
            r_exp_q     <= '0;
            r_sgn_big_q <= 1'b0;
            r_sgn_sml_q <= 1'b0;
            r_swp_q     <= 1'b0;
            r_stk_q     <= 1'b0;
        end else if (w_accept) begin
            sh_sel      <= w_sel;
            sh_f        <= w_man_sml;
            r_big_q     <= w_man_big;
            r_exp_q     <= w_eexp_big;
            r_sgn_big_q <= w_a_big ? op_a[SGN_B] : op_b[SGN_B];
            r_sgn_sml_q <= w_a_big ? op_b[SGN_B] : op_a[SGN_B];
            r_swp_q     <= ~w_a_big;
            r_stk_q     <= w_sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            big_man  <= '0;
            sml_man  <= '0;
            exp_out  <= '0;
            sign_big <= 1'b0;
            sign_sml <= 1'b0;
            swapped  <= 1'b0;
            sticky   <= 1'b0;
        end else if (w_capture) begin
            big_man  <= r_big_q;
            sml_man  <= sh_q;
            exp_out  <= r_exp_q;
            sign_big <= r_sgn_big_q;
            sign_sml <= r_sgn_sml_q;
            swapped  <= r_swp_q;
            sticky   <= r_stk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ALIGN;
            end
            ALIGN: w_next = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed bench for fp_align_ctrl with a behavioural model of the external shifter.
module tb_fp_align_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  sh_sel;
    logic [23:0] sh_f;
    logic [23:0] sh_q;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] big_man, sml_man;
    logic [7:0]  exp_out;
    logic        sign_big, sign_sml, swapped, sticky;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign sh_q = (sh_sel > 5'd23) ? 24'd0 : (sh_f >> sh_sel);

    fp_align_ctrl #(.EXP_W(8), .MAN_W(24), .SEL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sh_sel(sh_sel), .sh_f(sh_f), .sh_q(sh_q),
        .out_valid(out_valid), .out_ready(out_ready), .big_man(big_man),
        .sml_man(sml_man), .exp_out(exp_out), .sign_big(sign_big),
        .sign_sml(sign_sml), .swapped(swapped), .sticky(sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".latency"}, 32'(cyc <= 2), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [23:0] e_f, input logic [4:0] e_sel,
                         input logic [23:0] e_big, input logic [23:0] e_sml,
                         input logic [7:0] e_exp, input logic e_stk, input logic e_swp,
                         input logic e_sb, input logic e_ss);
        int cyc;
        in_valid = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        chk({tag, ".in_ready_align"}, 32'(in_ready), 32'd0);
        chk({tag, ".out_valid_align"}, 32'(out_valid), 32'd0);
        chk({tag, ".sh_sel"}, 32'(sh_sel), 32'(e_sel));
        chk({tag, ".sh_f"}, 32'(sh_f), 32'(e_f));
        wait_valid(tag, cyc);
        chk({tag, ".big_man"}, 32'(big_man), 32'(e_big));
        chk({tag, ".sml_man"}, 32'(sml_man), 32'(e_sml));
        chk({tag, ".exp_out"}, 32'(exp_out), 32'(e_exp));
        chk({tag, ".sticky"}, 32'(sticky), 32'(e_stk));
        chk({tag, ".swapped"}, 32'(swapped), 32'(e_swp));
        chk({tag, ".sign_big"}, 32'(sign_big), 32'(e_sb));
        chk({tag, ".sign_sml"}, 32'(sign_sml), 32'(e_ss));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_done"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sh_sel", 32'(sh_sel), 32'd0);
        chk("rst.sh_f", 32'(sh_f), 32'd0);
        chk("rst.big_man", 32'(big_man), 32'd0);
        chk("rst.exp_out", 32'(exp_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //          a             b             sh_f        sel    big         sml         exp    stk   swp   sb    ss
        do_op("eq",   32'h3F800000, 32'h3F800000, 24'h800000, 5'd0,  24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("d1",   32'h3F800000, 32'h40400000, 24'h800000, 5'd1,  24'hC00000, 24'h400000, 8'd128, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("d1stk",32'h3F800001, 32'hC0000000, 24'h800001, 5'd1,  24'h800000, 24'h400000, 8'd128, 1'b1, 1'b1, 1'b1, 1'b0);
        do_op("d23",  32'h4B000001, 32'h3F800001, 24'h800001, 5'd23, 24'h800001, 24'h000001, 8'd150, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("sat",  32'h7F000000, 32'h3F800000, 24'h800000, 5'd31, 24'h800000, 24'h000000, 8'd254, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("denrm",32'h80000003, 32'h00800000, 24'h000003, 5'd0,  24'h800000, 24'h000003, 8'd1,   1'b0, 1'b1, 1'b0, 1'b1);

        // Result held against backpressure while a new operand is offered.
        in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("hold", cyc);
        in_valid = 1'b1; op_a = 32'h40000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            chk("hold.big_man", 32'(big_man), 32'h800000);
            chk("hold.exp_out", 32'(exp_out), 32'd127);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold.rel_in_ready", 32'(in_ready), 32'd1);
        chk("hold.rel_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("hold.not_taken", 32'(in_ready), 32'd1);

        // Reset pulsed while the operation sits in ALIGN.
        in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h40400000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mrst.in_align", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        chk("mrst.sh_sel", 32'(sh_sel), 32'd0);
        chk("mrst.sh_f", 32'(sh_f), 32'd0);
        chk("mrst.big_man", 32'(big_man), 32'd0);
        chk("mrst.exp_out", 32'(exp_out), 32'd0);
        chk("mrst.swapped", 32'(swapped), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mrst.no_valid", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
